binary_add_4_1: RTL and testbench

// - Registered 4-bit binary adder: S = A + B (mod 2^WIDTH), captured on clk rising edge when en=1.
// - Built as a ripple chain of 1-bit full adders (sum = a^b^c, carry = ab|ac|bc) feeding an output register.
// - Leaf arithmetic block for datapaths that need a one-cycle-latency unsigned add with hold/enable control.

---
 rtl/binary_add_4_1.sv | 86 ++++++++
 tb/tb_binary_add_4_1.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/binary_add_4_1.sv
// -----------------------------------------------------------------------------
// binary_add_4_1
// Registered unsigned adder: S = A + B (mod 2^WIDTH), one cycle of latency.
// The sum is formed by a ripple chain of 1-bit full adders and captured in an
// output register whenever en is high; with en low the register holds.
//
// Ports
//   clk    in   1      clock, all state changes on the rising edge
//   rst_n  in   1      asynchronous reset, active HIGH despite the name
//   en     in   1      capture enable (1 = load new sum, 0 = hold)
//   A      in   WIDTH  unsigned addend
//   B      in   WIDTH  unsigned addend
//   S      out  WIDTH  registered sum, low WIDTH bits of A+B (wraps silently)
//   cout   out  1      registered carry-out (only with BINARY_ADD_COUT_EN)
//
// Configuration macro
//   BINARY_ADD_COUT_EN  when defined, exports the final carry as cout,
//                       registered with the same enable/reset as S.
// -----------------------------------------------------------------------------
module binary_add_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S
`ifdef BINARY_ADD_COUT_EN
  ,
  output logic             cout
`endif
);

  // carry[i] is the carry into bit i; carry[0] is tied low (plain add).
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] sum_reg;

  assign carry[0] = 1'b0;

`ifdef BINARY_ADD_COUT_EN
  logic cout_next;
  logic cout_reg;
`endif

  // Ripple chain. The carry out of the top bit is only built when it is
  // exported, so the default build carries no dangling logic.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum_next[gi] = A[gi] ^ B[gi] ^ carry[gi];
      if (gi < WIDTH - 1) begin : g_mid
        assign carry[gi+1] = (A[gi] & B[gi]) | (A[gi] & carry[gi]) | (B[gi] & carry[gi]);
      end else begin : g_top
`ifdef BINARY_ADD_COUT_EN
        assign cout_next = (A[gi] & B[gi]) | (A[gi] & carry[gi]) | (B[gi] & carry[gi]);
`endif
      end
    end
  endgenerate

  // Output register. Reset is asynchronous so S clears without a clock edge;
  // with en low the previous value is kept, which also keeps X on A/B out.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sum_reg <= '0;
    end else if (en) begin
      sum_reg <= sum_next;
    end
  end

  assign S = sum_reg;

`ifdef BINARY_ADD_COUT_EN
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cout_reg <= 1'b0;
    end else if (en) begin
      cout_reg <= cout_next;
    end
  end

  assign cout = cout_reg;
`endif

endmodule

// File: tb/tb_binary_add_4_1.sv
// -----------------------------------------------------------------------------
// tb_binary_add_4_1
// Scoreboard bench for binary_add_4_1. The driver applies inputs on the
// falling edge and queues the value S (and cout) must show after the next
// rising edge; an independent monitor pops and compares one entry per cycle.
// Asynchronous-reset and pre-edge latency checks are made directly.
// -----------------------------------------------------------------------------
module tb_binary_add_4_1;

  typedef struct {
    string      name;
    logic [3:0] s;
    logic       c;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] S;
`ifdef BINARY_ADD_COUT_EN
  logic       cout;
`endif

  exp_t exp_q[$];
  int   checks;
  int   failures;

  binary_add_4_1 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .A     (A),
    .B     (B),
    .S     (S)
`ifdef BINARY_ADD_COUT_EN
    ,
    .cout  (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Direct check of S against a required value.
  task automatic chk_s(input string nm, input logic [3:0] exp_s);
    checks++;
    if (S !== exp_s) begin
      failures++;
      $display("FAIL %s: S=%0d required %0d", nm, S, exp_s);
    end else begin
      $display("ok   %s: S=%0d", nm, S);
    end
  endtask

  // Queue the expected result for the coming rising edge.
  task automatic push(input string nm, input logic [3:0] s, input logic c);
    exp_t e;
    e.name = nm;
    e.s    = s;
    e.c    = c;
    exp_q.push_back(e);
  endtask

  // Apply a vector on the falling edge and queue its expected result.
  task automatic drive(input string nm, input logic e_en, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] s, input logic c);
    @(negedge clk);
    en = e_en;
    A  = a;
    B  = b;
    push(nm, s, c);
  endtask

  // Monitor: one comparison per cycle, 1 time unit after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        logic c_act;
        e = exp_q.pop_front();
`ifdef BINARY_ADD_COUT_EN
        c_act = cout;
`else
        c_act = e.c;
`endif
        checks++;
        if (S !== e.s || c_act !== e.c) begin
          failures++;
          $display("FAIL %s: S=%0d cout=%b required S=%0d cout=%b", e.name, S, c_act, e.s, e.c);
        end else begin
          $display("ok   %s: S=%0d cout=%b", e.name, S, c_act);
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d entries pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] full;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    en       = 1'b0;
    A        = 4'd0;
    B        = 4'd0;

    // Reset held for 10 time units.
    #10;
    chk_s("reset_S", 4'd0);
`ifdef BINARY_ADD_COUT_EN
    checks++;
    if (cout !== 1'b0) begin
      failures++;
      $display("FAIL reset_cout: cout=%b required 0", cout);
    end
`endif

    // Release reset on a falling edge with en low and X operands:
    // the register must hold 0 and never show X.
    @(negedge clk);
    rst_n = 1'b0;
    A     = 4'bxxxx;
    B     = 4'bxxxx;
    push("hold_x_after_reset", 4'd0, 1'b0);
    drive("hold_x_after_reset2", 1'b0, 4'bxxxx, 4'bxxxx, 4'd0, 1'b0);

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        full = 5'(a) + 5'(b);
        drive($sformatf("add_%0d_%0d", a, b), 1'b1, 4'(a), 4'(b), full[3:0], full[4]);
      end
    end

    // Wrap boundaries (hand-computed).
    drive("wrap_15_1",  1'b1, 4'd15, 4'd1,  4'd0,  1'b1);
    drive("wrap_15_15", 1'b1, 4'd15, 4'd15, 4'd14, 1'b1);
    drive("wrap_8_8",   1'b1, 4'd8,  4'd8,  4'd0,  1'b1);
    drive("zero_0_0",   1'b1, 4'd0,  4'd0,  4'd0,  1'b0);
    drive("add_7_8",    1'b1, 4'd7,  4'd8,  4'd15, 1'b0);

    // Enable hold.
    drive("hold_load_3_4", 1'b1, 4'd3, 4'd4, 4'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive($sformatf("hold_cycle_%0d", i), 1'b0, 4'd9, 4'd5, 4'd7, 1'b0);
    end
    drive("hold_release_9_5", 1'b1, 4'd9, 4'd5, 4'd14, 1'b0);

    // Latency: new operands on the falling edge must not show before the rise.
    drive("latency_2_2", 1'b1, 4'd2, 4'd2, 4'd4, 1'b0);
    #1;
    chk_s("latency_before_edge", 4'd14);

    // Load 9, then assert reset mid-cycle with no clock edge.
    drive("pre_reset_4_5", 1'b1, 4'd4, 4'd5, 4'd9, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk_s("async_reset_clears", 4'd0);
    // Held in reset across a rising edge with en=1: sum is lost.
    @(posedge clk);
    #1;
    chk_s("reset_blocks_capture", 4'd0);
    @(negedge clk);
    rst_n = 1'b0;
    push("first_after_release", 4'd9, 1'b0);
    drive("post_reset_15_1", 1'b1, 4'd15, 4'd1, 4'd0, 1'b1);

    // Drain: every queued expectation must have been consumed.
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
